// File: rtl/pe_net_iface_pkg.sv
// -----------------------------------------------------------------------------
// pe_net_iface_pkg
// Shared definitions for the PE-side network interface: statistics counter
// width/type and a saturating increment helper used by the stats block.
// -----------------------------------------------------------------------------
package pe_net_iface_pkg;

  localparam int unsigned StatsWidth = 16;

  typedef logic [StatsWidth-1:0] stat_t;

  // Increment by one when en is set, sticking at all-ones instead of wrapping.
  function automatic stat_t stat_inc(input stat_t value, input logic en);
    if (en && (value != '1)) return value + stat_t'(1);
    return value;
  endfunction

endpackage

// File: rtl/pe_net_iface_if.sv
// -----------------------------------------------------------------------------
// pe_net_iface_if
// Bundles the PE-side and NoC-side valid/ready channels of one PE network
// interface. Member names are given from the network interface's point of
// view (i_ = into the interface block, o_ = out of it).
//   PE TX  : i_pe_tx_data, i_pe_tx_dest, i_pe_tx_valid, o_pe_tx_ready
//   PE RX  : o_pe_rx_data, o_pe_rx_valid, i_pe_rx_ready
//   NoC TX : o_noc_data {dest,data}, o_noc_data_valid, i_noc_data_ready
//   NoC RX : i_noc_data {dest,data}, i_noc_data_valid, o_noc_data_ready
// Modports: slave  - the network interface block itself
//           master - the environment (PE + NoC side)
// -----------------------------------------------------------------------------
interface pe_net_iface_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 3
);

  logic [DataWidth-1:0]           i_pe_tx_data;
  logic [AddrWidth-1:0]           i_pe_tx_dest;
  logic                           i_pe_tx_valid;
  logic                           o_pe_tx_ready;

  logic [DataWidth-1:0]           o_pe_rx_data;
  logic                           o_pe_rx_valid;
  logic                           i_pe_rx_ready;

  logic [DataWidth+AddrWidth-1:0] o_noc_data;
  logic                           o_noc_data_valid;
  logic                           i_noc_data_ready;

  logic [DataWidth+AddrWidth-1:0] i_noc_data;
  logic                           i_noc_data_valid;
  logic                           o_noc_data_ready;

  modport slave (
    input  i_pe_tx_data, i_pe_tx_dest, i_pe_tx_valid, i_pe_rx_ready,
    input  i_noc_data_ready, i_noc_data, i_noc_data_valid,
    output o_pe_tx_ready, o_pe_rx_data, o_pe_rx_valid,
    output o_noc_data, o_noc_data_valid, o_noc_data_ready
  );

  modport master (
    output i_pe_tx_data, i_pe_tx_dest, i_pe_tx_valid, i_pe_rx_ready,
    output i_noc_data_ready, i_noc_data, i_noc_data_valid,
    input  o_pe_tx_ready, o_pe_rx_data, o_pe_rx_valid,
    input  o_noc_data, o_noc_data_valid, o_noc_data_ready
  );

endinterface

// File: rtl/net_sync_fifo.sv
// -----------------------------------------------------------------------------
// net_sync_fifo
// First-word-fall-through synchronous FIFO. The head entry is visible on
// o_rd_data whenever o_empty is low; i_rd_en pops it on the rising edge.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// full/empty come straight from registered pointers: a pop in the same cycle
// as a full condition does not admit a push until the next cycle.
// Ports:
//   i_sclk, i_reset       clock, synchronous active-high reset
//   i_wr_en, i_wr_data    push request/data (ignored while full)
//   i_rd_en               pop request (ignored while empty)
//   o_rd_data             head entry
//   o_full, o_empty       status
// Depth must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module net_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             i_sclk,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [Width-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [Width-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AddrW = $clog2(Depth);
  localparam int PtrW  = AddrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                   (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);

  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is defined by the
  // pointers alone, so stale contents are never observable.
  always_ff @(posedge i_sclk) begin
    if (w_wr) r_mem[r_wr_ptr[AddrW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[AddrW-1:0]];

endmodule

// File: rtl/pe_net_iface.sv
// -----------------------------------------------------------------------------
// pe_net_iface
// PE-side network interface for the 8-PE binary-tree NoC (one per PE port).
// PE payloads are packed into flits {dest, data} (dest in the MSBs) and queued
// in a TX FIFO towards the NoC. Sends addressed to this PE loop back straight
// into the RX FIFO. Flits from the NoC carrying a foreign destination are
// accepted, discarded and flagged on the sticky o_misroute output.
// Ports:
//   i_sclk, i_reset   clock, synchronous active-high reset
//   bus (slave)       PE TX/RX and NoC TX/RX valid/ready channels
//   o_misroute        sticky foreign-destination flag, cleared by reset
//   o_tx_count        NoC TX handshakes    (saturating, 16 bit)
//   o_rx_count        words delivered to PE (saturating, 16 bit)
//   o_drop_count      misrouted flits      (saturating, 16 bit)
// Build option: define PE_NET_IFACE_STATS_EN to implement the three counters;
// without it they are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module pe_net_iface
  import pe_net_iface_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 3,
  parameter int MyAddr    = 0,
  parameter int TxDepth   = 4,
  parameter int RxDepth   = 4
) (
  input  logic          i_sclk,
  input  logic          i_reset,
  pe_net_iface_if.slave bus,
  output logic          o_misroute,
  output stat_t         o_tx_count,
  output stat_t         o_rx_count,
  output stat_t         o_drop_count
);

  localparam int FlitWidth = DataWidth + AddrWidth;
  localparam logic [AddrWidth-1:0] MyAddrL = AddrWidth'(MyAddr);

  logic                 w_tx_full;
  logic                 w_tx_empty;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic                 w_loop_req;
  logic                 w_noc_dest_ok;
  logic                 w_noc_hs;
  logic                 w_noc_wr;
  logic                 w_misroute_hs;
  logic                 w_loop_grant;
  logic                 w_pe_hs;
  logic                 w_tx_wr;
  logic                 w_rx_wr;
  logic [DataWidth-1:0] w_rx_wr_data;
  logic                 r_misroute;

  // ---- NoC receive side -----------------------------------------------------
  assign w_noc_dest_ok = (bus.i_noc_data[FlitWidth-1 -: AddrWidth] == MyAddrL);
  assign bus.o_noc_data_ready = !w_rx_full;
  assign w_noc_hs      = bus.i_noc_data_valid && !w_rx_full;
  assign w_noc_wr      = w_noc_hs && w_noc_dest_ok;
  assign w_misroute_hs = w_noc_hs && !w_noc_dest_ok;

  // ---- PE transmit side / loopback arbitration ------------------------------
  // The RX FIFO has a single write port; a good NoC flit owns it, a loopback
  // beat only gets it when no NoC write happens (a dropped flit does not count).
  assign w_loop_req   = (bus.i_pe_tx_dest == MyAddrL);
  assign w_loop_grant = !w_rx_full && !w_noc_wr;
  assign bus.o_pe_tx_ready = !w_tx_full && (!w_loop_req || w_loop_grant);
  assign w_pe_hs      = bus.i_pe_tx_valid && bus.o_pe_tx_ready;
  assign w_tx_wr      = w_pe_hs && !w_loop_req;

  assign w_rx_wr      = w_noc_wr || (w_pe_hs && w_loop_req);
  assign w_rx_wr_data = w_noc_wr ? bus.i_noc_data[DataWidth-1:0] : bus.i_pe_tx_data;

  net_sync_fifo #(.Width(FlitWidth), .Depth(TxDepth)) u_tx_fifo (
    .i_sclk    (i_sclk),
    .i_reset   (i_reset),
    .i_wr_en   (w_tx_wr),
    .i_wr_data ({bus.i_pe_tx_dest, bus.i_pe_tx_data}),
    .i_rd_en   (bus.i_noc_data_ready),
    .o_rd_data (bus.o_noc_data),
    .o_full    (w_tx_full),
    .o_empty   (w_tx_empty)
  );

  assign bus.o_noc_data_valid = !w_tx_empty;

  net_sync_fifo #(.Width(DataWidth), .Depth(RxDepth)) u_rx_fifo (
    .i_sclk    (i_sclk),
    .i_reset   (i_reset),
    .i_wr_en   (w_rx_wr),
    .i_wr_data (w_rx_wr_data),
    .i_rd_en   (bus.i_pe_rx_ready),
    .o_rd_data (bus.o_pe_rx_data),
    .o_full    (w_rx_full),
    .o_empty   (w_rx_empty)
  );

  assign bus.o_pe_rx_valid = !w_rx_empty;

  // ---- Sticky misroute flag -------------------------------------------------
  always_ff @(posedge i_sclk) begin
    if (i_reset) r_misroute <= 1'b0;
    else if (w_misroute_hs) r_misroute <= 1'b1;
  end

  assign o_misroute = r_misroute;

  // ---- Statistics -----------------------------------------------------------
`ifdef PE_NET_IFACE_STATS_EN
  logic  w_noc_tx_hs;
  logic  w_pe_rx_hs;
  stat_t r_tx_count;
  stat_t r_rx_count;
  stat_t r_drop_count;

  assign w_noc_tx_hs = !w_tx_empty && bus.i_noc_data_ready;
  assign w_pe_rx_hs  = !w_rx_empty && bus.i_pe_rx_ready;

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_tx_count   <= '0;
      r_rx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      r_tx_count   <= stat_inc(r_tx_count, w_noc_tx_hs);
      r_rx_count   <= stat_inc(r_rx_count, w_pe_rx_hs);
      r_drop_count <= stat_inc(r_drop_count, w_misroute_hs);
    end
  end

  assign o_tx_count   = r_tx_count;
  assign o_rx_count   = r_rx_count;
  assign o_drop_count = r_drop_count;
`else
  assign o_tx_count   = '0;
  assign o_rx_count   = '0;
  assign o_drop_count = '0;
`endif

endmodule
